qsram_controller: RTL and testbench

Command sequencer that sits directly upstream of the SDR QSRAM device model and drives its Address, Enable, Read, Write and Refresh pins and its bidirectional data bus. It accepts single-word read/write requests from a host over a valid/ready handshake and converts each into a correctly timed SRAM bus cycle. It also issues periodic refresh bursts that take priority over new host requests. Read data returns to the host as a one-cycle response pulse after a fixed latency.

---
 rtl/qsram_pkg.sv | 29 ++
 rtl/qsram_refresh_timer.sv | 31 +++
 rtl/qsram_controller.sv | 162 ++++++++++++++++
 tb/tb_qsram_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qsram_pkg: shared state encoding, default sizes, config check      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package qsram_pkg;

  localparam int unsigned DEF_ADDR_WIDTH       = 30;
  localparam int unsigned DEF_DATA_WIDTH       = 9;
  localparam int unsigned DEF_READ_LATENCY     = 2;
  localparam int unsigned DEF_REFRESH_INTERVAL = 1024;
  localparam int unsigned DEF_REFRESH_CYCLES   = 4;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_WRITE        = 3'd1;
  localparam logic [2:0] ST_READ_WAIT    = 3'd2;
  localparam logic [2:0] ST_READ_CAPTURE = 3'd3;
  localparam logic [2:0] ST_REFRESH      = 3'd4;

  // A refresh period must fit the longest transaction plus the burst itself.
  function automatic bit qsram_cfg_ok(input int unsigned read_latency,
                                      input int unsigned refresh_cycles,
                                      input int unsigned refresh_interval);
    return (read_latency >= 1) && (refresh_cycles >= 1) &&
           (refresh_interval > refresh_cycles + read_latency + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/qsram_refresh_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qsram_refresh_timer: free-running reload counter, expiry strobe    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module qsram_refresh_timer #(
  parameter int unsigned INTERVAL = 1024
) (
  input  logic clk,
  input  logic rst,
  output logic o_expire
);

  localparam int unsigned     CW       = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CW-1:0]   C_RELOAD = CW'(INTERVAL - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = (count_q == '0) ? C_RELOAD : count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= C_RELOAD;
    else     count_q <= count_d;
  end

  assign o_expire = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/qsram_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qsram_controller: host request to QSRAM bus cycle sequencer        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module qsram_controller
  import qsram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int unsigned READ_LATENCY     = DEF_READ_LATENCY,
  parameter int unsigned REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
  parameter int unsigned REFRESH_CYCLES   = DEF_REFRESH_CYCLES
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [ADDR_WIDTH-1:0] ReqAddress,
  input  logic [DATA_WIDTH-1:0] ReqData,
  output logic                  RspValid,
  output logic [DATA_WIDTH-1:0] RspData,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  Enable,
  output logic                  Read,
  output logic                  Write,
  output logic                  Refresh,
  inout  wire  [DATA_WIDTH-1:0] inoutData
);

  localparam int unsigned   WAIT_MAX     = (READ_LATENCY > REFRESH_CYCLES) ? READ_LATENCY : REFRESH_CYCLES;
  localparam int unsigned   WW           = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WW-1:0] READ_LOAD    = WW'(READ_LATENCY - 1);
  localparam logic [WW-1:0] REFRESH_LOAD = WW'(REFRESH_CYCLES - 1);

  if (!qsram_cfg_ok(READ_LATENCY, REFRESH_CYCLES, REFRESH_INTERVAL)) begin : g_bad_config
    $error("qsram_controller: REFRESH_INTERVAL too short for READ_LATENCY/REFRESH_CYCLES");
  end

  logic [2:0]            state_q, state_d;
  logic                  pending_q, pending_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic                  enable_q, enable_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic                  refresh_q, refresh_d;
  logic                  bus_oe_q, bus_oe_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  expire;
  logic                  accept;

  qsram_refresh_timer #(
    .INTERVAL (REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk      (Clock),
    .rst      (Reset),
    .o_expire (expire)
  );

  assign ReqReady = (state_q == ST_IDLE) && !pending_q && !Reset;
  assign accept   = ReqValid && ReqReady;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | expire;
    wait_d      = wait_q;
    wdata_d     = wdata_q;
    address_d   = address_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // An expiry with no competing request starts the burst right away.
        if (pending_q || (expire && !accept)) begin
          state_d = ST_REFRESH;
          wait_d  = REFRESH_LOAD;
        end else if (accept) begin
          wdata_d   = ReqData;
          address_d = ReqAddress;
          if (ReqWrite) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ_WAIT;
            wait_d  = READ_LOAD;
          end
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ_WAIT: begin
        if (wait_q == '0) state_d = ST_READ_CAPTURE;
        else              wait_d  = wait_q - 1'b1;
      end
      ST_READ_CAPTURE: begin
        rsp_data_d  = inoutData;
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_REFRESH: begin
        if (wait_q == '0) begin
          state_d   = ST_IDLE;
          pending_d = expire;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pins are decoded from the next state so they appear registered.
    write_d   = (state_d == ST_WRITE);
    read_d    = (state_d == ST_READ_WAIT);
    refresh_d = (state_d == ST_REFRESH);
    enable_d  = write_d | read_d | refresh_d;
    bus_oe_d  = write_d;
    if (!(write_d || read_d)) address_d = '0;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      pending_q   <= 1'b0;
      wait_q      <= '0;
      wdata_q     <= '0;
      address_q   <= '0;
      enable_q    <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      refresh_q   <= 1'b0;
      bus_oe_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      wait_q      <= wait_d;
      wdata_q     <= wdata_d;
      address_q   <= address_d;
      enable_q    <= enable_d;
      read_q      <= read_d;
      write_q     <= write_d;
      refresh_q   <= refresh_d;
      bus_oe_q    <= bus_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign Address   = address_q;
  assign Enable    = enable_q;
  assign Read      = read_q;
  assign Write     = write_q;
  assign Refresh   = refresh_q;
  assign RspValid  = rsp_valid_q;
  assign RspData   = rsp_data_q;
  assign inoutData = bus_oe_q ? wdata_q : 'z;

endmodule
`default_nettype wire

// File: tb/tb_qsram_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_qsram_controller: directed vector bench for qsram_controller    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_qsram_controller;

  localparam int AW = 30;
  localparam int DW = 9;
  localparam int RL = 2;
  localparam int RC = 4;
  localparam int RI = 16;
  localparam int NV = 38;

  logic          clk = 1'b0;
  logic          rst;
  logic          ReqValid, ReqReady, ReqWrite;
  logic [AW-1:0] ReqAddress;
  logic [DW-1:0] ReqData;
  logic          RspValid;
  logic [DW-1:0] RspData;
  logic [AW-1:0] Address;
  logic          Enable, Read, Write, Refresh;
  wire  [DW-1:0] inoutData;
  logic          mdl_en;
  logic [DW-1:0] mdl_val;

  // SRAM read-data driver; the bench decides when the device returns data.
  assign inoutData = mdl_en ? mdl_val : 'z;

  always #5 clk = ~clk;

  qsram_controller #(
    .ADDR_WIDTH       (AW),
    .DATA_WIDTH       (DW),
    .READ_LATENCY     (RL),
    .REFRESH_INTERVAL (RI),
    .REFRESH_CYCLES   (RC)
  ) dut (
    .Clock      (clk),
    .Reset      (rst),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqWrite   (ReqWrite),
    .ReqAddress (ReqAddress),
    .ReqData    (ReqData),
    .RspValid   (RspValid),
    .RspData    (RspData),
    .Address    (Address),
    .Enable     (Enable),
    .Read       (Read),
    .Write      (Write),
    .Refresh    (Refresh),
    .inoutData  (inoutData)
  );

  // Expected word layout: {rdy, en, rd, wr, ref, addr[29:0], rsp, rdata[8:0]}
  typedef struct packed {
    logic          rv;
    logic          rw;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          men;
    logic [DW-1:0] mval;
    logic [44:0]   exp;
    logic          drv;
    logic [DW-1:0] bus;
  } vec_t;

  vec_t vecs [NV];
  int   nvec = 0;
  int   nmis = 0;

  function automatic logic [44:0] ex(input int rdy, input int en, input int rd, input int wr,
                                     input int rf, input int addr, input int rsp, input int rdata);
    return {1'(rdy), 1'(en), 1'(rd), 1'(wr), 1'(rf), 30'(addr), 1'(rsp), 9'(rdata)};
  endfunction

  function automatic vec_t mv(input int rv, input int rw, input int ra, input int rd,
                              input int men, input int mval, input logic [44:0] e,
                              input int drv, input int bus);
    vec_t v;
    v.rv = 1'(rv); v.rw = 1'(rw); v.ra = 30'(ra); v.rd = 9'(rd);
    v.men = 1'(men); v.mval = 9'(mval); v.exp = e; v.drv = 1'(drv); v.bus = 9'(bus);
    return v;
  endfunction

  function automatic logic [44:0] obs();
    return {ReqReady, Enable, Read, Write, Refresh, Address, RspValid, RspData};
  endfunction

  function automatic bit bus_ok(input logic drv, input logic [DW-1:0] eb);
    if (drv)    return inoutData === eb;
    if (mdl_en) return inoutData === mdl_val;
    return (inoutData === {DW{1'bz}}) || (inoutData === {DW{1'b0}});
  endfunction

  task automatic check(input string name, input int idx, input logic [44:0] e,
                       input logic drv, input logic [DW-1:0] eb);
    logic [44:0] act;
    act = obs();
    nvec++;
    if (act !== e || !bus_ok(drv, eb)) begin
      nmis++;
      $display("FAIL %s #%0d: got pins=%h bus=%h, expected pins=%h bus=%h (drive=%0b)",
               name, idx, act, inoutData, e, eb, drv);
    end
  endtask

  task automatic apply(input vec_t v);
    ReqValid   = v.rv;
    ReqWrite   = v.rw;
    ReqAddress = v.ra;
    ReqData    = v.rd;
    mdl_en     = v.men;
    mdl_val    = v.mval;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            seq, bursts, run;
    bit            adv;
    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_data[$];
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;

    rst = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddress = '0; ReqData = '0;
    mdl_en = 1'b0; mdl_val = '0;

    // Cycle k counts from reset release; the timer expires in cycles 15, 31, ...
    for (int i = 0; i < 5; i++) vecs[i] = mv(0,0,0,0,0,0, ex(1,0,0,0,0,0,0,0), 0,0);
    vecs[5]  = mv(1,1,'h15,'h1A5,0,0, ex(1,0,0,0,0,0,0,0), 0,0);
    vecs[6]  = mv(0,0,0,0,0,0,        ex(0,1,0,1,0,'h15,0,0), 1,'h1A5);
    vecs[7]  = mv(1,1,'h2A,'h055,0,0, ex(1,0,0,0,0,0,0,0), 0,0);
    vecs[8]  = mv(1,1,'h3F,'h1FF,0,0, ex(0,1,0,1,0,'h2A,0,0), 1,'h055);
    vecs[9]  = mv(1,1,'h3F,'h1FF,0,0, ex(1,0,0,0,0,0,0,0), 0,0);
    vecs[10] = mv(0,0,0,0,0,0,        ex(0,1,0,1,0,'h3F,0,0), 1,'h1FF);
    vecs[11] = mv(1,0,'h7,0,0,0,      ex(1,0,0,0,0,0,0,0), 0,0);
    vecs[12] = mv(0,0,0,0,0,0,        ex(0,1,1,0,0,'h7,0,0), 0,0);
    vecs[13] = mv(0,0,0,0,0,0,        ex(0,1,1,0,0,'h7,0,0), 0,0);
    vecs[14] = mv(0,0,0,0,1,'h0C3,    ex(0,0,0,0,0,0,0,0), 0,0);
    vecs[15] = mv(1,0,'h12,0,0,0,     ex(1,0,0,0,0,0,1,'h0C3), 0,0);
    vecs[16] = mv(0,0,0,0,0,0,        ex(0,1,1,0,0,'h12,0,'h0C3), 0,0);
    vecs[17] = mv(0,0,0,0,0,0,        ex(0,1,1,0,0,'h12,0,'h0C3), 0,0);
    vecs[18] = mv(0,0,0,0,1,'h13C,    ex(0,0,0,0,0,0,0,'h0C3), 0,0);
    vecs[19] = mv(1,1,'hAA,'h0F0,0,0, ex(0,0,0,0,0,0,1,'h13C), 0,0);
    for (int i = 20; i < 24; i++) vecs[i] = mv(1,1,'hAA,'h0F0,0,0, ex(0,1,0,0,1,0,0,'h13C), 0,0);
    vecs[24] = mv(1,1,'hAA,'h0F0,0,0, ex(1,0,0,0,0,0,0,'h13C), 0,0);
    vecs[25] = mv(0,0,0,0,0,0,        ex(0,1,0,1,0,'hAA,0,'h13C), 1,'h0F0);
    for (int i = 26; i < 32; i++) vecs[i] = mv(0,0,0,0,0,0, ex(1,0,0,0,0,0,0,'h13C), 0,0);
    for (int i = 32; i < 36; i++) vecs[i] = mv(0,0,0,0,0,0, ex(0,1,0,0,1,0,0,'h13C), 0,0);
    for (int i = 36; i < NV; i++) vecs[i] = mv(0,0,0,0,0,0, ex(1,0,0,0,0,0,0,'h13C), 0,0);

    #1 check("reset_state", 0, ex(0,0,0,0,0,0,0,0), 1'b0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", 0, ex(0,0,0,0,0,0,0,0), 1'b0, '0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (i > 0) @(negedge clk);
      apply(vecs[i]);
      #1;
      check("table", i, vecs[i].exp, vecs[i].drv, vecs[i].bus);
    end

    // Continuous write stream across four refresh periods (cycles 38..106).
    seq = 0; bursts = 0; run = 0; adv = 1'b0;
    mdl_en = 1'b0;
    for (int c = 0; c < 69; c++) begin
      @(negedge clk);
      if (adv) seq++;
      adv        = 1'b0;
      ReqValid   = (c < 66);
      ReqWrite   = 1'b1;
      ReqAddress = 30'h100 + 30'(seq);
      ReqData    = 9'(seq * 7 + 3);
      #1;
      if (ReqValid && ReqReady) begin
        q_addr.push_back(ReqAddress);
        q_data.push_back(ReqData);
        adv = 1'b1;
      end
      if (Write) begin
        nvec++;
        if (q_addr.size() == 0) begin
          nmis++;
          $display("FAIL stream_write: unexpected write addr=%h bus=%h", Address, inoutData);
        end else begin
          ea = q_addr.pop_front();
          ed = q_data.pop_front();
          if (Address !== ea || inoutData !== ed) begin
            nmis++;
            $display("FAIL stream_write: got addr=%h bus=%h, expected addr=%h bus=%h",
                     Address, inoutData, ea, ed);
          end
        end
      end
      if (Refresh) begin
        run++;
        nvec++;
        if (ReqReady !== 1'b0 || Enable !== 1'b1 || Address !== '0) begin
          nmis++;
          $display("FAIL stream_refresh_pins: got rdy=%b en=%b addr=%h, expected rdy=0 en=1 addr=0",
                   ReqReady, Enable, Address);
        end
      end else if (run > 0) begin
        nvec++;
        if (run != RC) begin
          nmis++;
          $display("FAIL stream_burst_len: got %0d cycles, expected %0d", run, RC);
        end
        bursts++;
        run = 0;
      end
    end
    nvec++;
    if (bursts != 4) begin
      nmis++;
      $display("FAIL stream_bursts: got %0d, expected 4", bursts);
    end
    nvec++;
    if (seq != 23 || q_addr.size() != 0) begin
      nmis++;
      $display("FAIL stream_accepts: got %0d accepted, %0d outstanding, expected 23 and 0",
               seq, q_addr.size());
    end

    // Reset during READ_WAIT discards the read; the next read is normal.
    @(negedge clk);
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddress = 30'h21; ReqData = '0;
    #1 check("rst_seq_accept", 0, ex(1,0,0,0,0,0,0,'h13C), 1'b0, '0);
    @(negedge clk);
    ReqValid = 1'b0;
    #1 check("rst_seq_readwait", 0, ex(0,1,1,0,0,'h21,0,'h13C), 1'b0, '0);
    #2 rst = 1'b1;
    #1 check("rst_async", 0, ex(0,0,0,0,0,0,0,0), 1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1 check("rst_quiet", i, ex(1,0,0,0,0,0,0,0), 1'b0, '0);
    end
    @(negedge clk);
    ReqValid = 1'b1; ReqAddress = 30'h33;
    #1 check("post_rst_accept", 0, ex(1,0,0,0,0,0,0,0), 1'b0, '0);
    @(negedge clk);
    ReqValid = 1'b0;
    #1 check("post_rst_read", 1, ex(0,1,1,0,0,'h33,0,0), 1'b0, '0);
    @(negedge clk);
    #1 check("post_rst_read", 2, ex(0,1,1,0,0,'h33,0,0), 1'b0, '0);
    @(negedge clk);
    mdl_en = 1'b1; mdl_val = 9'h0A5;
    #1 check("post_rst_capture", 3, ex(0,0,0,0,0,0,0,0), 1'b0, '0);
    @(negedge clk);
    mdl_en = 1'b0;
    #1 check("post_rst_rsp", 4, ex(1,0,0,0,0,0,1,'h0A5), 1'b0, '0);
    @(negedge clk);
    #1 check("post_rst_rsp_end", 5, ex(1,0,0,0,0,0,0,'h0A5), 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
